// File: rtl/pit_bus_if.sv
// CPU-side bus of the PIT: chip select, read/write strobes, address and data.
// The CPU (or bench) drives the master side and the controller takes the slave side.
interface pit_bus_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] a;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs_n, wr_n, rd_n, a, din, input dout);
    modport slave  (input cs_n, wr_n, rd_n, a, din, output dout);
endinterface

// File: rtl/pit_bus_ctrl.sv
// 8254-style bus decoder and per-channel configuration for three counters.
// Sequences LSB/MSB count loads, handles counter latch commands and serves count reads.
module pit_bus_ctrl #(
    parameter int NCH = 3,
    parameter int W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pit_bus_if.slave           bus,
    input  logic [NCH*W-1:0]   cnt_i,
    output logic [NCH*8-1:0]   msb_o,
    output logic [NCH*8-1:0]   lsb_o,
    output logic [NCH*3-1:0]   mode_o,
    output logic [NCH-1:0]     bcd_o,
    output logic [NCH-1:0]     load_o,
    output logic [NCH-1:0]     cfg_o
);

    logic         wr_q, rd_q;
    logic         wr_ev, rd_ev;
    logic [1:0]   rw        [NCH];
    logic         wtog      [NCH];
    logic         rtog      [NCH];
    logic         latch_full[NCH];
    logic [W-1:0] latch_val [NCH];
    logic [7:0]   hold_lsb  [NCH];
    logic [W-1:0] src       [NCH];
    logic [2:0]   mode_new;

    // A write event pre-empts a read event arriving in the same cycle.
    assign wr_ev    = !bus.cs_n && !bus.wr_n && wr_q;
    assign rd_ev    = !bus.cs_n && !bus.rd_n && rd_q && !wr_ev;
    assign mode_new = (bus.din[3] && bus.din[2]) ? {1'b0, bus.din[2:1]} : bus.din[3:1];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            src[c] = latch_full[c] ? latch_val[c] : cnt_i[c*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            bus.dout <= '0;
            msb_o    <= '0;
            lsb_o    <= '0;
            mode_o   <= '0;
            bcd_o    <= '0;
            load_o   <= '0;
            cfg_o    <= '0;
            for (int c = 0; c < NCH; c++) begin
                rw[c]         <= 2'b01;
                wtog[c]       <= 1'b0;
                rtog[c]       <= 1'b0;
                latch_full[c] <= 1'b0;
                latch_val[c]  <= '0;
                hold_lsb[c]   <= '0;
            end
        end else begin
            wr_q   <= bus.wr_n;
            rd_q   <= bus.rd_n;
            load_o <= '0;
            cfg_o  <= '0;
            if (wr_ev && bus.a == 2'd3) begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.din[7:6] == 2'(c)) begin
                        if (bus.din[5:4] == 2'b00) begin
                            if (!latch_full[c]) begin
                                latch_val[c]  <= cnt_i[c*W +: W];
                                latch_full[c] <= 1'b1;
                            end
                        end else begin
                            rw[c]            <= bus.din[5:4];
                            mode_o[c*3 +: 3] <= mode_new;
                            bcd_o[c]         <= bus.din[0];
                            wtog[c]          <= 1'b0;
                            rtog[c]          <= 1'b0;
                            latch_full[c]    <= 1'b0;
                            msb_o[c*8 +: 8]  <= '0;
                            lsb_o[c*8 +: 8]  <= '0;
                            cfg_o[c]         <= 1'b1;
                        end
                    end
                end
            end else if (wr_ev) begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.a == 2'(c)) begin
                        case (rw[c])
                            2'b01: begin
                                lsb_o[c*8 +: 8] <= bus.din;
                                msb_o[c*8 +: 8] <= '0;
                                load_o[c]       <= 1'b1;
                            end
                            2'b10: begin
                                msb_o[c*8 +: 8] <= bus.din;
                                lsb_o[c*8 +: 8] <= '0;
                                load_o[c]       <= 1'b1;
                            end
                            default: begin
                                // Outputs only change once both bytes are in, so the counter never sees a half count.
                                if (!wtog[c]) begin
                                    hold_lsb[c] <= bus.din;
                                    wtog[c]     <= 1'b1;
                                end else begin
                                    lsb_o[c*8 +: 8] <= hold_lsb[c];
                                    msb_o[c*8 +: 8] <= bus.din;
                                    wtog[c]         <= 1'b0;
                                    load_o[c]       <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end else if (rd_ev && bus.a != 2'd3) begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.a == 2'(c)) begin
                        case (rw[c])
                            2'b01: begin
                                bus.dout      <= src[c][7:0];
                                latch_full[c] <= 1'b0;
                            end
                            2'b10: begin
                                bus.dout      <= src[c][15:8];
                                latch_full[c] <= 1'b0;
                            end
                            default: begin
                                if (!rtog[c]) begin
                                    bus.dout <= src[c][7:0];
                                    rtog[c]  <= 1'b1;
                                end else begin
                                    bus.dout      <= src[c][15:8];
                                    rtog[c]       <= 1'b0;
                                    latch_full[c] <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pit_bus_ctrl.sv
// Directed bench for pit_bus_ctrl: a vector table of bus accesses with hand-computed
// expected outputs, followed by held-strobe, simultaneous-strobe and mid-sequence reset cases.
module tb_pit_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic [47:0] cnt_i;
    logic [23:0] msb_o, lsb_o;
    logic [8:0]  mode_o;
    logic [2:0]  bcd_o, load_o, cfg_o;
    int          pass_count;
    int          total_count;

    pit_bus_if bus ();

    pit_bus_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .cnt_i  (cnt_i),
        .msb_o  (msb_o),
        .lsb_o  (lsb_o),
        .mode_o (mode_o),
        .bcd_o  (bcd_o),
        .load_o (load_o),
        .cfg_o  (cfg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [1:0]  a;
        logic [7:0]  din;
        logic [47:0] cnt;
        logic [2:0]  load;
        logic [2:0]  cfg;
        logic [7:0]  dout;
        logic [23:0] lsb;
        logic [23:0] msb;
        logic [8:0]  mode;
        logic [2:0]  bcd;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One bus access: strobe asserted for exactly one cycle, then released and idle.
    task automatic applyStimulus(input bit rd, input logic [1:0] a, input logic [7:0] din,
                                 input logic [47:0] cnt);
        @(posedge clk); #1;
        bus.a    = a;
        bus.din  = din;
        cnt_i    = cnt;
        bus.cs_n = 1'b0;
        if (rd) bus.rd_n = 1'b0;
        else    bus.wr_n = 1'b0;
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dout"},   {40'd0, bus.dout}, 48'd0);
        checkOutput({tag, " lsb"},    {24'd0, lsb_o},    48'd0);
        checkOutput({tag, " msb"},    {24'd0, msb_o},    48'd0);
        checkOutput({tag, " mode"},   {39'd0, mode_o},   48'd0);
        checkOutput({tag, " bcd"},    {45'd0, bcd_o},    48'd0);
        checkOutput({tag, " load"},   {45'd0, load_o},   48'd0);
        checkOutput({tag, " cfg"},    {45'd0, cfg_o},    48'd0);
    endtask

    initial begin
        int loads;
        pass_count  = 0;
        total_count = 0;

        //           rd  a     din    cnt                  load  cfg   dout   lsb        msb        mode    bcd
        vecs[0]  = '{0, 2'd3, 8'h34, 48'h0,              3'b000, 3'b001, 8'h00, 24'h000000, 24'h000000, 9'h002, 3'b000};
        vecs[1]  = '{0, 2'd0, 8'h10, 48'h0,              3'b000, 3'b000, 8'h00, 24'h000000, 24'h000000, 9'h002, 3'b000};
        vecs[2]  = '{0, 2'd0, 8'h27, 48'h0,              3'b001, 3'b000, 8'h00, 24'h000010, 24'h000027, 9'h002, 3'b000};
        vecs[3]  = '{0, 2'd3, 8'h5E, 48'h0,              3'b000, 3'b010, 8'h00, 24'h000010, 24'h000027, 9'h01A, 3'b000};
        vecs[4]  = '{0, 2'd1, 8'h05, 48'h0,              3'b010, 3'b000, 8'h00, 24'h000510, 24'h000027, 9'h01A, 3'b000};
        vecs[5]  = '{0, 2'd3, 8'hB4, 48'h0,              3'b000, 3'b100, 8'h00, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[6]  = '{0, 2'd3, 8'h80, 48'hABCD_0000_0000, 3'b000, 3'b000, 8'h00, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[7]  = '{0, 2'd3, 8'h80, 48'h1234_0000_0000, 3'b000, 3'b000, 8'h00, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[8]  = '{1, 2'd2, 8'h00, 48'h1234_0000_0000, 3'b000, 3'b000, 8'hCD, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[9]  = '{1, 2'd2, 8'h00, 48'h1234_0000_0000, 3'b000, 3'b000, 8'hAB, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[10] = '{1, 2'd2, 8'h00, 48'h1234_0000_0000, 3'b000, 3'b000, 8'h34, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[11] = '{0, 2'd0, 8'h11, 48'h0,              3'b000, 3'b000, 8'h34, 24'h000510, 24'h000027, 9'h09A, 3'b000};
        vecs[12] = '{0, 2'd1, 8'h66, 48'h0,              3'b010, 3'b000, 8'h34, 24'h006610, 24'h000027, 9'h09A, 3'b000};
        vecs[13] = '{0, 2'd0, 8'h22, 48'h0,              3'b001, 3'b000, 8'h34, 24'h006611, 24'h000022, 9'h09A, 3'b000};
        vecs[14] = '{1, 2'd1, 8'h00, 48'h0000_4321_0000, 3'b000, 3'b000, 8'h21, 24'h006611, 24'h000022, 9'h09A, 3'b000};
        vecs[15] = '{0, 2'd3, 8'h73, 48'h0,              3'b000, 3'b010, 8'h21, 24'h000011, 24'h000022, 9'h08A, 3'b010};
        vecs[16] = '{1, 2'd1, 8'h00, 48'h0000_4321_0000, 3'b000, 3'b000, 8'h21, 24'h000011, 24'h000022, 9'h08A, 3'b010};
        vecs[17] = '{1, 2'd1, 8'h00, 48'h0000_4321_0000, 3'b000, 3'b000, 8'h43, 24'h000011, 24'h000022, 9'h08A, 3'b010};
        vecs[18] = '{0, 2'd3, 8'h24, 48'h0,              3'b000, 3'b001, 8'h43, 24'h000000, 24'h000000, 9'h08A, 3'b010};
        vecs[19] = '{0, 2'd0, 8'h9C, 48'h0,              3'b001, 3'b000, 8'h43, 24'h000000, 24'h00009C, 9'h08A, 3'b010};
        vecs[20] = '{1, 2'd0, 8'h00, 48'h0000_0000_5A77, 3'b000, 3'b000, 8'h5A, 24'h000000, 24'h00009C, 9'h08A, 3'b010};

        rst_n    = 1'b0;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.a    = 2'd0;
        bus.din  = 8'h00;
        cnt_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].a, vecs[i].din, vecs[i].cnt);
            checkOutput($sformatf("v%0d load", i), {45'd0, load_o},   {45'd0, vecs[i].load});
            checkOutput($sformatf("v%0d cfg", i),  {45'd0, cfg_o},    {45'd0, vecs[i].cfg});
            checkOutput($sformatf("v%0d dout", i), {40'd0, bus.dout}, {40'd0, vecs[i].dout});
            checkOutput($sformatf("v%0d lsb", i),  {24'd0, lsb_o},    {24'd0, vecs[i].lsb});
            checkOutput($sformatf("v%0d msb", i),  {24'd0, msb_o},    {24'd0, vecs[i].msb});
            checkOutput($sformatf("v%0d mode", i), {39'd0, mode_o},   {39'd0, vecs[i].mode});
            checkOutput($sformatf("v%0d bcd", i),  {45'd0, bcd_o},    {45'd0, vecs[i].bcd});
        end

        // Held-low write strobe: ch0 is rw=10 here, so one event gives exactly one load.
        loads = 0;
        @(posedge clk); #1;
        bus.a    = 2'd0;
        bus.din  = 8'h42;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            loads += int'(load_o[0]);
        end
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        @(posedge clk); #1;
        loads += int'(load_o[0]);
        checkOutput("held wr load count", 48'(loads), 48'd1);
        checkOutput("held wr load idle",  {45'd0, load_o}, 48'd0);
        checkOutput("held wr msb",        {24'd0, msb_o},  48'h000042);
        checkOutput("held wr lsb",        {24'd0, lsb_o},  48'h000000);

        // Simultaneous read and write events: write wins, dout keeps its last value.
        @(posedge clk); #1;
        bus.a    = 2'd0;
        bus.din  = 8'h55;
        cnt_i    = 48'h0000_0000_EEEE;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.rd_n = 1'b0;
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        checkOutput("rdwr load", {45'd0, load_o},   48'b001);
        checkOutput("rdwr msb",  {24'd0, msb_o},    48'h000055);
        checkOutput("rdwr dout", {40'd0, bus.dout}, 48'h5A);

        // Reset in the middle of an rw=11 load discards the held byte.
        applyStimulus(1'b0, 2'd3, 8'h34, 48'h0);
        applyStimulus(1'b0, 2'd0, 8'h10, 48'h0);
        #3;
        rst_n = 1'b0;
        #2;
        checkAllZero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h77, 48'h0);
        checkOutput("post reset load", {45'd0, load_o}, 48'b001);
        checkOutput("post reset lsb",  {24'd0, lsb_o},  48'h000077);
        checkOutput("post reset msb",  {24'd0, msb_o},  48'h000000);
        checkOutput("post reset cfg",  {45'd0, cfg_o},  48'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/pit_bus_ctrl.md
Name: pit_bus_ctrl

Overview:
- Bus interface and configuration controller for the three 8254-style counter channels (Mode0..Mode5 blocks).
- Decodes CPU writes and reads on the 8-bit PIT bus (A1:A0, CS_n, RD_n, WR_n) and holds per-channel mode/RW/BCD configuration.
- Sequences LSB/MSB count loading into each channel and issues one-cycle load/config strobes.
- Serves count reads, including counter-latch commands, from the channels' live count values.

Parameters:
- NCH, 3, number of counter channels (fixed at 3; address 3 = control word).
- W, 16, count width per channel.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, active low, synchronous to clk.
- wr_n  in  1  write strobe, active low, synchronous.
- rd_n  in  1  read strobe, active low, synchronous.
- a  in  2  address: 0..2 = counter data, 3 = control word.
- din  in  8  write data.
- dout  out  8  registered read data.
- cnt_i  in  48  live count of channels {c2,c1,c0}, 16 b each.
- msb_o  out  24  per-channel initial-count MSB {c2,c1,c0}.
- lsb_o  out  24  per-channel initial-count LSB {c2,c1,c0}.
- mode_o  out  9  per-channel mode, 3 b each.
- bcd_o  out  3  per-channel BCD flag.
- load_o  out  3  one-cycle pulse: new initial count valid.
- cfg_o  out  3  one-cycle pulse: control word written to channel.

Behaviour:
- Reset (async, rst_n=0): dout=0, msb_o=lsb_o=0, mode_o=0, bcd_o=0, load_o=0, cfg_o=0, all channels rw=01, write/read toggles=LSB, latches empty. Reset mid-sequence discards partial bytes and latched values.
- Strobe detect: write event when cs_n=0 and wr_n=0 this cycle while wr_n was 1 the previous cycle; read event is the same with rd_n. A held-low strobe is one event. A write and a read event in the same cycle: the write is processed and the read is ignored.
- Control word (a=3), din[7:6]=SC selects channel 0..2. SC=11 (read-back) is ignored, with no state change.
- din[5:4]=RW:
  - RW=00: counter latch command. If the channel latch is empty, capture cnt_i[ch] and mark it full. If already full, ignore.
  - RW≠00: store rw, store mode=din[3:1] (11x maps to 01x: 110→010, 111→011), store bcd=din[0]. Reset that channel's write and read toggles to LSB, clear its latch, zero its msb_o/lsb_o, and pulse cfg_o[ch] the next cycle.
- Count write (a=0..2):
  - rw=01: lsb_o=din, msb_o=0, load pulse.
  - rw=10: msb_o=din, lsb_o=0, load pulse.
  - rw=11: first byte goes to a holding LSB with toggle→MSB. Second byte sets lsb_o=holding and msb_o=din (updated together), toggle→LSB, load pulse.
- Load timing: load_o[ch] is high exactly one cycle, the cycle after the completing write event. msb_o/lsb_o are valid in that cycle and held until the next completed load or a control word.
- Count read (a=0..2):
  - Source is the latch if full, else cnt_i[ch].
  - rw=01 returns the LSB; rw=10 returns the MSB.
  - rw=11 returns LSB then MSB via the read toggle.
  - dout is updated at the clock edge ending the read-event cycle and held until the next read.
  - The latch empties after the last byte of the rw sequence has been read (one read for 01/10, two reads for 11).
  - An unlatched rw=11 read samples cnt_i live on each byte.
- Independence: the three channels' toggles and latches are fully independent; interleaved accesses to other channels do not disturb a pending sequence.
- A write to a channel while its latch is full does not affect the latch.

Test Plan:
- Reset then control 0x34 (ch0, rw=11, mode 2), write 0x10 then 0x27 to a=0 → cfg_o[0] pulses once. load_o[0] pulses once, only after the second byte, with lsb_o=0x10 and msb_o=0x27. mode_o[2:0]=010.
- Control 0x5E (ch1, rw=01, mode 111→011, bcd=0), write 0x05 to a=1 → immediate load_o[1] with lsb=0x05, msb=0x00, mode_o[5:3]=011.
- Ch2 rw=11, cnt_i[2]=0xABCD, latch cmd 0x80, then cnt_i→0x1234, second latch cmd, then two reads a=2 → dout 0xCD then 0xAB. A third read returns live 0x34.
- Ch0 rw=11: write one byte 0x11, write to ch1, then second ch0 byte 0x22 → ch0 load with 0x2211. Ch1 is unaffected by the ch0 toggle.
- wr_n held low for 5 cycles with a single byte → one event only. Simultaneous rd/wr events → write applied and dout unchanged.
- Assert rst_n mid rw=11 sequence (after the first byte) → all outputs 0. A subsequent single write under default rw=01 loads immediately.
